// File: rtl/morse_symbol_keyer.sv
// Morse symbol keyer: turns one character (element pattern + length) into a keyed
// on/off line with dot = 1 unit, dash = 3 units, element space 1 unit, character gap 3 units.
module morse_symbol_keyer #(
  parameter int UNIT_CYCLES = 4,
  parameter int MAX_LEN     = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               char_valid,
  output logic               char_ready,
  input  logic [2:0]         char_len,
  input  logic [MAX_LEN-1:0] char_pat,
  output logic               key_out,
  output logic               busy,
  output logic [2:0]         elem_idx
);

  localparam int CW = $clog2(3*UNIT_CYCLES+1);
  localparam logic [CW-1:0] ONE_UNIT   = CW'(UNIT_CYCLES-1);
  localparam logic [CW-1:0] THREE_UNIT = CW'(3*UNIT_CYCLES-1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, CHAR_GAP} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         len;
  logic [MAX_LEN-1:0] pat;
  logic [7:0]         patx;
  logic [2:0]         nidx;
  logic               len_ok;

  assign patx       = 8'(pat);
  assign nidx       = elem_idx + 3'd1;
  assign len_ok     = (char_len >= 3'd1) && (char_len <= 3'd5);
  assign char_ready = (state == IDLE) & ~RST;

  // Counter holds remaining cycles minus one, so a d-unit state lasts exactly d*UNIT_CYCLES cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      pat      <= '0;
      elem_idx <= '0;
      key_out  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid && len_ok) begin
            len      <= char_len;
            pat      <= char_pat;
            elem_idx <= '0;
            state    <= MARK;
            key_out  <= 1'b1;
            busy     <= 1'b1;
            cnt      <= char_pat[0] ? THREE_UNIT : ONE_UNIT;
          end
        end
        MARK: begin
          if (cnt == '0) begin
            key_out <= 1'b0;
            if (elem_idx < len - 3'd1) begin
              state <= SPACE;
              cnt   <= ONE_UNIT;
            end else begin
              state <= CHAR_GAP;
              cnt   <= THREE_UNIT;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        SPACE: begin
          if (cnt == '0) begin
            elem_idx <= nidx;
            state    <= MARK;
            key_out  <= 1'b1;
            cnt      <= patx[nidx] ? THREE_UNIT : ONE_UNIT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        CHAR_GAP: begin
          if (cnt == '0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            elem_idx <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          key_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_keyer.sv
// Testbench for morse_symbol_keyer: directed and random characters compared cycle by cycle
// against an expected waveform built from Morse timing rules.
module tb_morse_symbol_keyer;

  localparam int U = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       char_valid;
  logic       char_ready;
  logic [2:0] char_len;
  logic [4:0] char_pat;
  logic       key_out;
  logic       busy;
  logic [2:0] elem_idx;

  int checks = 0;
  int errors = 0;

  morse_symbol_keyer #(.UNIT_CYCLES(U), .MAX_LEN(5)) dut (
    .CLK(CLK), .RST(RST), .char_valid(char_valid), .char_ready(char_ready),
    .char_len(char_len), .char_pat(char_pat), .key_out(key_out),
    .busy(busy), .elem_idx(elem_idx)
  );

  initial forever #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected waveform: each element's mark, a 1-unit space between elements, then a 3-unit gap.
  task automatic checkChar(input int len, input logic [4:0] pat);
    bit key_q[$];
    int idx_q[$];
    for (int e = 0; e < len; e++) begin
      for (int c = 0; c < (pat[e] ? 3 : 1) * U; c++) begin key_q.push_back(1'b1); idx_q.push_back(e); end
      if (e < len - 1)
        for (int c = 0; c < U; c++) begin key_q.push_back(1'b0); idx_q.push_back(e); end
    end
    for (int c = 0; c < 3 * U; c++) begin key_q.push_back(1'b0); idx_q.push_back(len - 1); end
    for (int k = 0; k < key_q.size(); k++) begin
      @(negedge CLK);
      checkOutput($sformatf("key c%0d", k + 1), 8'(key_out), 8'(key_q[k]));
      checkOutput($sformatf("idx c%0d", k + 1), 8'(elem_idx), 8'(idx_q[k]));
      checkOutput($sformatf("busy c%0d", k + 1), 8'(busy), 8'd1);
      checkOutput($sformatf("ready c%0d", k + 1), 8'(char_ready), 8'd0);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " ready"}, 8'(char_ready), 8'd1);
    checkOutput({tag, " busy"}, 8'(busy), 8'd0);
    checkOutput({tag, " key"}, 8'(key_out), 8'd0);
    checkOutput({tag, " idx"}, 8'(elem_idx), 8'd0);
  endtask

  task automatic applyStimulus(input logic [2:0] len, input logic [4:0] pat);
    @(negedge CLK);
    checkOutput("ready before send", 8'(char_ready), 8'd1);
    char_valid = 1'b1;
    char_len   = len;
    char_pat   = pat;
    @(posedge CLK);
    #1;
    char_valid = 1'b0;
    char_len   = 3'($urandom);
    char_pat   = 5'($urandom);
    checkChar(int'(len), pat);
    @(negedge CLK);
    checkIdle("after char");
  endtask

  initial begin
    RST = 1'b1; char_valid = 1'b0; char_len = '0; char_pat = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("ready in reset", 8'(char_ready), 8'd0);
    RST = 1'b0;
    @(negedge CLK);
    checkIdle("reset");

    applyStimulus(3'd1, 5'b00000);
    applyStimulus(3'd2, 5'b00010);
    applyStimulus(3'd5, 5'b11111);
    applyStimulus(3'd3, 5'b11010);

    // Second character held valid while 'E' is in progress.
    @(negedge CLK);
    char_valid = 1'b1; char_len = 3'd1; char_pat = 5'b00000;
    @(posedge CLK);
    #1;
    char_len = 3'd1; char_pat = 5'b00001;
    checkChar(1, 5'b00000);
    @(negedge CLK);
    checkOutput("b2b ready c17", 8'(char_ready), 8'd1);
    checkOutput("b2b key c17", 8'(key_out), 8'd0);
    @(posedge CLK);
    #1;
    char_valid = 1'b0;
    checkChar(1, 5'b00001);
    @(negedge CLK);
    checkIdle("after b2b");

    // Illegal lengths are consumed and dropped.
    foreach (char_pat[i]) begin end
    for (int l = 0; l < 3; l++) begin
      @(negedge CLK);
      char_valid = 1'b1;
      char_len   = (l == 0) ? 3'd0 : (l == 1) ? 3'd6 : 3'd7;
      char_pat   = 5'($urandom);
      @(posedge CLK);
      #1;
      char_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge CLK);
        checkIdle($sformatf("badlen%0d c%0d", l, c));
      end
    end

    // Reset in the second cycle of a dash.
    @(negedge CLK);
    char_valid = 1'b1; char_len = 3'd1; char_pat = 5'b00001;
    @(posedge CLK);
    #1;
    char_valid = 1'b0;
    @(negedge CLK);
    checkOutput("dash c1 key", 8'(key_out), 8'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("dash c2 key", 8'(key_out), 8'd1);
    checkOutput("ready during rst", 8'(char_ready), 8'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checkIdle("after mid rst");

    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      applyStimulus(3'($urandom_range(1, 5)), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
